// File: rtl/mdc_commutator.sv
// Delay-commutator stage of a multi-path delay-commutator FFT: reorders the
// upper/lower lane pair so the downstream butterfly sees partners DELAY beats apart.
module mdc_commutator #(
  parameter int DW    = 9,
  parameter int DELAY = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in0_re,
  input  logic signed [DW-1:0] in0_im,
  input  logic signed [DW-1:0] in1_re,
  input  logic signed [DW-1:0] in1_im,
  output logic                 out_valid,
  output logic signed [DW-1:0] out0_re,
  output logic signed [DW-1:0] out0_im,
  output logic signed [DW-1:0] out1_re,
  output logic signed [DW-1:0] out1_im,
  output logic                 sw_state
);

  localparam int SW = 2 * DW;
  localparam int CW = $clog2(2 * DELAY);
  localparam int PW = $clog2(DELAY + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(2 * DELAY - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(DELAY);
  localparam logic [PW-1:0] PRIME_FULL = PW'(DELAY);

  logic [CW-1:0] cnt_reg;
  logic [PW-1:0] prime_reg;
  logic          out_valid_reg;
  logic          sw_state_reg;
  logic [SW-1:0] out0_reg;
  logic [SW-1:0] out1_reg;

  logic          sel;
  logic          accept;
  logic [SW-1:0] a_word;
  logic [SW-1:0] b_word;
  logic [SW-1:0] ua;
  logic [SW-1:0] top;
  logic [SW-1:0] low_pre;
  logic [SW-1:0] low;

  // Tap arrays are only ever driven by continuous assigns; the stage
  // registers live inside the generate blocks.
  logic [SW-1:0] up_tap [DELAY+1];
  logic [SW-1:0] lo_tap [DELAY+1];

  assign accept = in_valid & ~clr;
  assign sel    = (cnt_reg >= CNT_HALF);
  assign a_word = {in0_re, in0_im};
  assign b_word = {in1_re, in1_im};

  assign up_tap[0] = a_word;
  assign ua        = up_tap[DELAY];

  assign top     = sel ? b_word : ua;
  assign low_pre = sel ? ua     : b_word;

  assign lo_tap[0] = low_pre;
  assign low       = lo_tap[DELAY];

  // Both delay lines only shift on accepted beats, so gaps in in_valid are transparent.
  for (genvar gi = 0; gi < DELAY; gi++) begin : g_dly
    logic [SW-1:0] up_q;
    logic [SW-1:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        up_q <= '0;
        lo_q <= '0;
      end else if (accept) begin
        up_q <= up_tap[gi];
        lo_q <= lo_tap[gi];
      end
    end

    assign up_tap[gi+1] = up_q;
    assign lo_tap[gi+1] = lo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      prime_reg     <= '0;
      out_valid_reg <= 1'b0;
      sw_state_reg  <= 1'b0;
      out0_reg      <= '0;
      out1_reg      <= '0;
    end else if (clr) begin
      cnt_reg       <= '0;
      prime_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else if (in_valid) begin
      cnt_reg       <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
      // Saturating prime count keeps stale delay-line contents from ever being flagged valid.
      if (prime_reg != PRIME_FULL) begin
        prime_reg <= prime_reg + 1'b1;
      end
      out_valid_reg <= (prime_reg == PRIME_FULL);
      sw_state_reg  <= sel;
      out0_reg      <= top;
      out1_reg      <= low;
    end else begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign sw_state  = sw_state_reg;
  assign out0_re   = out0_reg[SW-1:DW];
  assign out0_im   = out0_reg[DW-1:0];
  assign out1_re   = out1_reg[SW-1:DW];
  assign out1_im   = out1_reg[DW-1:0];

endmodule

// File: tb/tb_mdc_commutator.sv
// Scoreboard bench for mdc_commutator: a DELAY=2 and a DELAY=8 instance see
// the same stimulus; each has its own reference model and expectation queue.
module tb_mdc_commutator;

  localparam int DW = 9;
  localparam int HN = 1024;

  typedef struct packed {
    logic        v;
    logic        sw;
    logic        sw_k;
    logic        data_k;
    logic [17:0] o0;
    logic [17:0] o1;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic in_valid;
  logic signed [DW-1:0] in0_re, in0_im, in1_re, in1_im;

  logic d2_valid, d2_sw, d8_valid, d8_sw;
  logic signed [DW-1:0] d2_o0_re, d2_o0_im, d2_o1_re, d2_o1_im;
  logic signed [DW-1:0] d8_o0_re, d8_o0_im, d8_o1_re, d8_o1_im;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  int   kcnt[2];
  logic [17:0] ha[2][HN];
  logic [17:0] hb[2][HN];

  always #5 clk = ~clk;

  mdc_commutator #(.DW(DW), .DELAY(2)) dut_d2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
    .out_valid(d2_valid),
    .out0_re(d2_o0_re), .out0_im(d2_o0_im), .out1_re(d2_o1_re), .out1_im(d2_o1_im),
    .sw_state(d2_sw)
  );

  mdc_commutator #(.DW(DW), .DELAY(8)) dut_d8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
    .out_valid(d8_valid),
    .out0_re(d8_o0_re), .out0_im(d8_o0_im), .out1_re(d8_o1_re), .out1_im(d8_o1_im),
    .sw_state(d8_sw)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] pk(input int re, input int im);
    logic [8:0] r;
    logic [8:0] i;
    r = 9'(re);
    i = 9'(im);
    return {r, i};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      kcnt[i] = 0;
      cur[i]  = '{v: 1'b0, sw: 1'b0, sw_k: 1'b1, data_k: 1'b1, o0: '0, o1: '0};
    end
  endtask

  // Expected outputs follow the lane mapping directly from the sample history.
  task automatic model_step(input int i, input logic v, input logic c,
                            input logic [17:0] a, input logic [17:0] b);
    exp_t e;
    int   d;
    int   k;
    logic s;
    d = (i == 0) ? 2 : 8;
    e = cur[i];
    if (c) begin
      kcnt[i] = 0;
      e.v = 1'b0;
    end else if (!v) begin
      e.v = 1'b0;
    end else begin
      k = kcnt[i];
      if (k >= HN) begin
        $display("FAIL model_history: got %0d expected below %0d", k, HN);
        $fatal(1, "history overflow");
      end
      ha[i][k] = a;
      hb[i][k] = b;
      s = ((k % (2 * d)) >= d);
      e.sw   = s;
      e.sw_k = 1'b1;
      e.v    = (k >= d);
      if (k >= d) begin
        e.data_k = 1'b1;
        if (s) begin
          e.o0 = b;
          e.o1 = hb[i][k-d];
        end else begin
          e.o0 = ha[i][k-d];
          e.o1 = ha[i][k-2*d];
        end
      end else begin
        e.data_k = 1'b0;
      end
      kcnt[i] = k + 1;
    end
    cur[i] = e;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input logic v, input logic c, input logic [17:0] a, input logic [17:0] b);
    @(negedge clk);
    in_valid = v;
    clr      = c;
    in0_re   = a[17:9];
    in0_im   = a[8:0];
    in1_re   = b[17:9];
    in1_im   = b[8:0];
    model_step(0, v, c, a, b);
    model_step(1, v, c, a, b);
    $display("txn v=%0b clr=%0b a=%05h b=%05h k2=%0d k8=%0d", v, c, a, b, kcnt[0], kcnt[1]);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, " d2 valid"}, d2_valid, 0);
    check_val({tag, " d2 sw"},    d2_sw,    0);
    check_val({tag, " d2 data"},  {d2_o0_re, d2_o0_im, d2_o1_re, d2_o1_im}, 0);
    check_val({tag, " d8 valid"}, d8_valid, 0);
    check_val({tag, " d8 sw"},    d8_sw,    0);
    check_val({tag, " d8 data"},  {d8_o0_re, d8_o0_im, d8_o1_re, d8_o1_im}, 0);
  endtask

  exp_t m0;
  exp_t m1;
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      m0 = q0.pop_front();
      check_val("d2 valid", d2_valid, m0.v);
      if (m0.sw_k)   check_val("d2 sw", d2_sw, m0.sw);
      if (m0.data_k) check_val("d2 out0", {d2_o0_re, d2_o0_im}, m0.o0);
      if (m0.data_k) check_val("d2 out1", {d2_o1_re, d2_o1_im}, m0.o1);
    end
    if (q1.size() > 0) begin
      m1 = q1.pop_front();
      check_val("d8 valid", d8_valid, m1.v);
      if (m1.sw_k)   check_val("d8 sw", d8_sw, m1.sw);
      if (m1.data_k) check_val("d8 out0", {d8_o0_re, d8_o0_im}, m1.o0);
      if (m1.data_k) check_val("d8 out1", {d8_o1_re, d8_o1_im}, m1.o1);
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Counting ramp: a(k)=k, b(k)=100+k
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b0, pk(k, -k), pk(100 + k, -(100 + k)));

    // Restart frame aborted by an asynchronous reset between edges
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, pk(k, -k), pk(100 + k, -(100 + k)));
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_zero("async rst");
    @(posedge clk);
    #2;
    check_zero("rst held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Same ramp with a 3-cycle in_valid gap between beats 3 and 4
    for (int k = 0; k < 12; k++) begin
      if (k == 4) for (int g = 0; g < 3; g++) drive(1'b0, 1'b0, pk(7, 7), pk(9, 9));
      drive(1'b1, 1'b0, pk(k, -k), pk(100 + k, -(100 + k)));
    end

    // clr coinciding with in_valid discards that beat and restarts numbering
    drive(1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, pk(20 + k, k), pk(40 + k, -k));
    drive(1'b1, 1'b1, pk(77, 77), pk(88, 88));
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, pk(50 + k, k), pk(-50 - k, -k));

    // Long continuous run across several counter wraps
    drive(1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 70; k++) drive(1'b1, 1'b0, 18'($urandom), 18'($urandom));

    // Signed extremes
    drive(1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) drive(1'b1, 1'b0, pk(-256, 255), pk(255, -256));
      else            drive(1'b1, 1'b0, pk(255, -256), pk(-256, 255));
    end

    // Random valid gaps with occasional clr
    drive(1'b0, 1'b1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
            18'($urandom), 18'($urandom));
    end

    drive(1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #3;
    check_val("queue drained", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
